vedic_pp_sum24: RTL and testbench

Final summation stage of the pipelined 12x12 unsigned Vedic multiplier. It consumes the four registered 12-bit 6x6 partial products from the partial-product register stage and combines them into the 24-bit product: q0 + ((q1 + q2) << 6) + (q3 << 12). It is a two-stage pipeline with valid/ready handshakes on both sides, so the FFT butterfly datapath downstream can stall it. An optional rounded 12-bit output feeds twiddle-multiply paths directly.

---
 rtl/vedic_pp_sum24.sv | 85 ++++++++
 tb/tb_vedic_pp_sum24.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vedic_pp_sum24.sv
// Final summation stage of the pipelined 12x12 Vedic multiplier: p = q0 + ((q1+q2)<<6) + (q3<<12).
// Two-stage valid/ready pipeline; define VPP_ROUND_EN to build the rounded 12-bit out_q.
module vedic_pp_sum24 (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] q0,
  input  logic [11:0] q1,
  input  logic [11:0] q2,
  input  logic [11:0] q3,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] out_p,
  output logic [11:0] out_q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        pp_err
);

  localparam logic [11:0] PP_MAX = 12'd3969;

  logic        s1_valid;
  logic [11:0] s1_q0;
  logic [11:0] s1_q3;
  logic [12:0] s1_mid;
  logic        s1_en;
  logic        s2_en;
  logic        accept;
  logic        pp_bad;
  logic [23:0] p;

  always_comb begin
    s2_en    = !out_valid || out_ready;
    s1_en    = !s1_valid || s2_en;
    in_ready = s1_en;
    accept   = in_valid && s1_en;
    pp_bad   = (q0 > PP_MAX) || (q1 > PP_MAX) || (q2 > PP_MAX) || (q3 > PP_MAX);
    // 24-bit sum gives the same result as a 25-bit sum truncated to 24 bits
    p = {12'b0, s1_q0} + {5'b0, s1_mid, 6'b0} + {s1_q3, 12'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_q0     <= '0;
      s1_q3     <= '0;
      s1_mid    <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
      pp_err    <= 1'b0;
    end else begin
      if (accept) begin
        s1_q0  <= q0;
        s1_q3  <= q3;
        s1_mid <= {1'b0, q1} + {1'b0, q2};
        if (pp_bad) pp_err <= 1'b1;
      end
      if (s1_en) s1_valid <= in_valid;
      if (s2_en) begin
        out_valid <= s1_valid;
        if (s1_valid) out_p <= p;
      end
    end
  end

`ifdef VPP_ROUND_EN
  logic [12:0] q_sum;
  logic [11:0] q_rnd;

  always_comb begin
    q_sum = {1'b0, p[23:12]} + {12'b0, p[11]};
    q_rnd = q_sum[12] ? 12'hFFF : q_sum[11:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else if (s2_en && s1_valid) begin
      out_q <= q_rnd;
    end
  end
`else
  always_comb out_q = '0;
`endif

endmodule

// File: tb/tb_vedic_pp_sum24.sv
// Scoreboard bench for vedic_pp_sum24 using directed vectors with hand-computed products.
module tb_vedic_pp_sum24;

  logic        clk;
  logic        rst;
  logic [11:0] q0, q1, q2, q3;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] out_p;
  logic [11:0] out_q;
  logic        out_valid;
  logic        out_ready;
  logic        pp_err;

  typedef struct packed {
    logic [23:0] p;
    logic [11:0] q;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  vedic_pp_sum24 dut (
    .clk(clk), .rst(rst),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_p(out_p), .out_q(out_q), .out_valid(out_valid), .out_ready(out_ready),
    .pp_err(pp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one beat; push the expected result when the handshake completes.
  task automatic send(input logic [11:0] a0, input logic [11:0] a1, input logic [11:0] a2,
                      input logic [11:0] a3, input logic [23:0] ep, input logic [11:0] eq,
                      output int waits);
    logic acc;
    exp_t e;
    q0 = a0; q1 = a1; q2 = a2; q3 = a3;
    in_valid = 1'b1;
    waits = 0;
    acc = 1'b0;
    while (!acc && waits < 50) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    if (!acc) chk("send_timeout", 24'd0, 24'd1);
    else begin
      e.p = ep;
`ifdef VPP_ROUND_EN
      e.q = eq;
`else
      e.q = 12'h000;
`endif
      sb.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_remaining", 24'(sb.size()), 24'd0);
  endtask

  // Monitor: a transfer completes at the next rising edge when valid && ready here.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", out_p, 24'hxxxxxx);
        end else begin
          e = sb.pop_front();
          chk("out_p", out_p, e.p);
          chk("out_q", {12'b0, out_q}, {12'b0, e.q});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

  logic [11:0] v0[8], v1[8], v2[8], v3[8];
  logic [23:0] vp[8];
  logic [11:0] vq[8];
  int          w;
  logic [23:0] held;

  initial begin
    v0 = '{12'd1, 12'd0, 12'd0, 12'd0, 12'd10, 12'd3969, 12'd0,    12'd0};
    v1 = '{12'd0, 12'd1, 12'd0, 12'd0, 12'd20, 12'd0,    12'd3969, 12'd0};
    v2 = '{12'd0, 12'd0, 12'd1, 12'd0, 12'd30, 12'd0,    12'd3969, 12'd0};
    v3 = '{12'd0, 12'd0, 12'd0, 12'd1, 12'd40, 12'd0,    12'd0,    12'd3969};
    vp = '{24'h000001, 24'h000040, 24'h000040, 24'h001000,
           24'h028C8A, 24'h000F81, 24'h07C080, 24'hF81000};
    vq = '{12'h000, 12'h000, 12'h000, 12'h001, 12'h029, 12'h001, 12'h07C, 12'hF81};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    q0 = '0; q1 = '0; q2 = '0; q3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {23'b0, out_valid}, 24'd0);
    chk("rst_out_p", out_p, 24'd0);
    chk("rst_out_q", {12'b0, out_q}, 24'd0);
    chk("rst_pp_err", {23'b0, pp_err}, 24'd0);
    chk("rst_in_ready", {23'b0, in_ready}, 24'd1);
    rst = 1'b0;

    // Max legal product and two-register latency
    send(12'd3969, 12'd3969, 12'd3969, 12'd3969, 24'hFFE001, 12'hFFE, w);
    chk("lat_edge1_valid", {23'b0, out_valid}, 24'd0);
    @(posedge clk); #1;
    chk("lat_edge2_valid", {23'b0, out_valid}, 24'd1);
    chk("max_pp_err", {23'b0, pp_err}, 24'd0);
    wait_empty();

    send(12'd770, 12'd88, 12'd595, 12'd68, 24'h04EDC2, 12'h04F, w);
    wait_empty();

    // Back-to-back stream: every beat accepted first try, results on consecutive cycles
    for (int i = 0; i < 8; i++) begin
      send(v0[i], v1[i], v2[i], v3[i], vp[i], vq[i], w);
      chk("stream_in_ready_waits", 24'(w), 24'd0);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("stream_no_bubble", 24'(sb.size()), 24'd0);
    wait_empty();

    // Backpressure: two results buffered, output held, drain in order
    out_ready = 1'b0;
    send(v0[0], v1[0], v2[0], v3[0], vp[0], vq[0], w);
    send(v0[1], v1[1], v2[1], v3[1], vp[1], vq[1], w);
    chk("stall_in_ready_low", {23'b0, in_ready}, 24'd0);
    held = out_p;
    chk("stall_out_p", held, 24'h000001);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("stall_out_p_stable", out_p, held);
    chk("stall_out_valid", {23'b0, out_valid}, 24'd1);
    chk("stall_in_ready_still_low", {23'b0, in_ready}, 24'd0);
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready_same_cycle", {23'b0, in_ready}, 24'd1);
    send(v0[2], v1[2], v2[2], v3[2], vp[2], vq[2], w);
    send(v0[3], v1[3], v2[3], v3[3], vp[3], vq[3], w);
    wait_empty();

    // Out-of-range partial products: sticky error, wrapped result, rounding saturation
    send(12'd0, 12'd0, 12'd0, 12'd4095, 24'hFFF000, 12'hFFF, w);
    chk("err_set", {23'b0, pp_err}, 24'd1);
    send(12'd4095, 12'd4095, 12'd4095, 12'd4095, 24'h07FF7F, 12'h080, w);
    send(12'd2048, 12'd0, 12'd0, 12'd4095, 24'hFFF800, 12'hFFF, w);
    send(v0[4], v1[4], v2[4], v3[4], vp[4], vq[4], w);
    wait_empty();
    chk("err_sticky", {23'b0, pp_err}, 24'd1);

    // Reset with both stages full discards in-flight results
    out_ready = 1'b0;
    send(v0[5], v1[5], v2[5], v3[5], vp[5], vq[5], w);
    send(v0[6], v1[6], v2[6], v3[6], vp[6], vq[6], w);
    chk("full_in_ready_low", {23'b0, in_ready}, 24'd0);
    sb.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", {23'b0, out_valid}, 24'd0);
    chk("midrst_out_p", out_p, 24'd0);
    chk("midrst_pp_err", {23'b0, pp_err}, 24'd0);
    chk("midrst_in_ready", {23'b0, in_ready}, 24'd1);
    rst = 1'b0;
    out_ready = 1'b1;
    send(v0[7], v1[7], v2[7], v3[7], vp[7], vq[7], w);
    wait_empty();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
